// File: rtl/trigger_sequencer.sv
// -----------------------------------------------------------------------------
// trigger_sequencer
//
// Trigger controller between the trigger sources (M3 GPIO, trace match) and the
// CW trig_out pin. Once armed it waits for a rising edge on the selected
// source, waits a programmable number of cycles, then drives a pulse of
// programmable width. It also counts emitted pulses (saturating).
// Everything runs in the trace_clk domain. Configuration inputs are assumed to
// be synchronous already.
//
// Build option:
//   TRIG_SEQ_GLITCH_FILTER_EN - when defined, a source must be seen high on
//   two consecutive samples before its rising edge qualifies. This adds one
//   cycle to every latency and rejects single-cycle glitches.
//
// Parameters:
//   pDELAY_WIDTH  width of the delay value
//   pPULSE_WIDTH  width of the pulse-length value
//   pCOUNT_WIDTH  width of the trigger counter
//
// Ports:
//   trace_clk         sole clock
//   reset             synchronous, active-high
//   I_m3_trig         M3 GPIO trigger level
//   I_trace_trig      trace-match trigger level
//   I_source_sel      0 = M3, 1 = trace, 2 = M3 | trace, 3 = M3 & trace
//   I_arm             single-cycle arm request (honoured only in IDLE)
//   I_disarm          single-cycle abort, wins over everything but reset
//   I_auto_rearm      return to ARMED after each pulse
//   I_delay           cycles from qualified edge to pulse start
//   I_pulse_len       pulse length in cycles (0 acts as 1)
//   I_count_clr       clears the trigger counter
//   O_trig_out        trigger pulse (decoded from the state register)
//   O_armed           high in ARMED
//   O_busy            high in DELAY or PULSE
//   O_capture_active  high in any state except IDLE
//   O_trig_count      number of pulses emitted, saturating
// -----------------------------------------------------------------------------
module trigger_sequencer #(
    parameter int pDELAY_WIDTH = 16,
    parameter int pPULSE_WIDTH = 16,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    trace_clk,
    input  logic                    reset,
    input  logic                    I_m3_trig,
    input  logic                    I_trace_trig,
    input  logic [1:0]              I_source_sel,
    input  logic                    I_arm,
    input  logic                    I_disarm,
    input  logic                    I_auto_rearm,
    input  logic [pDELAY_WIDTH-1:0] I_delay,
    input  logic [pPULSE_WIDTH-1:0] I_pulse_len,
    input  logic                    I_count_clr,
    output logic                    O_trig_out,
    output logic                    O_armed,
    output logic                    O_busy,
    output logic                    O_capture_active,
    output logic [pCOUNT_WIDTH-1:0] O_trig_count
);

    // One down-counter serves both DELAY and PULSE, so size it for the wider.
    localparam int CNT_W = (pDELAY_WIDTH > pPULSE_WIDTH) ? pDELAY_WIDTH : pPULSE_WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_PULSE = 2'd3;

    logic [1:0]              state;
    logic [1:0]              state_nxt;
    logic [CNT_W-1:0]        dcnt;
    logic [CNT_W-1:0]        dcnt_nxt;
    logic                    enter_pulse;

    // Shadow copies of the configuration, captured on the arm cycle.
    logic [pDELAY_WIDTH-1:0] sh_delay;
    logic [pPULSE_WIDTH-1:0] sh_len;
    logic [1:0]              sh_sel;
    logic                    sh_auto;

    logic [1:0]              sel_eff;
    logic                    src;
    logic                    src_d;
    logic                    qual_edge;

    logic [CNT_W-1:0]        delay_m1;
    logic [CNT_W-1:0]        len_m1;

    logic [pCOUNT_WIDTH-1:0] trig_count;

    // ------------------------------------------------------------------------
    // Source selection and edge detection
    // ------------------------------------------------------------------------
    // In IDLE the live select drives src so that src_d already reflects the
    // level of the chosen source when the arm arrives; a level that is high at
    // arm time therefore never looks like an edge. After arming, the shadow
    // copy (equal to the live value on the arm cycle) takes over.
    assign sel_eff = (state == ST_IDLE) ? I_source_sel : sh_sel;

    always_comb begin
        src = 1'b0;
        case (sel_eff)
            2'd0:    src = I_m3_trig;
            2'd1:    src = I_trace_trig;
            2'd2:    src = I_m3_trig | I_trace_trig;
            default: src = I_m3_trig & I_trace_trig;
        endcase
    end

`ifdef TRIG_SEQ_GLITCH_FILTER_EN
    logic src_dd;

    always_ff @(posedge trace_clk) begin
        if (reset) begin
            src_d  <= 1'b0;
            src_dd <= 1'b0;
        end else begin
            src_d  <= src;
            src_dd <= src_d;
        end
    end

    // Two consecutive high samples preceded by a low one.
    assign qual_edge = src & src_d & ~src_dd;
`else
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            src_d <= 1'b0;
        end else begin
            src_d <= src;
        end
    end

    assign qual_edge = src & ~src_d;
`endif

    // ------------------------------------------------------------------------
    // Counter reload values
    // ------------------------------------------------------------------------
    // delay_m1 is only used when sh_delay != 0, so the wrap at 0 is harmless.
    assign delay_m1 = CNT_W'(sh_delay) - CNT_W'(1);
    // A zero pulse length behaves as one cycle.
    assign len_m1   = (sh_len == '0) ? '0 : (CNT_W'(sh_len) - CNT_W'(1));

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        enter_pulse = 1'b0;

        case (state)
            ST_IDLE: begin
                if (I_arm) begin
                    state_nxt = ST_ARMED;
                end
            end

            ST_ARMED: begin
                if (qual_edge) begin
                    if (sh_delay == '0) begin
                        state_nxt   = ST_PULSE;
                        dcnt_nxt    = len_m1;
                        enter_pulse = 1'b1;
                    end else begin
                        state_nxt   = ST_DELAY;
                        dcnt_nxt    = delay_m1;
                    end
                end
            end

            ST_DELAY: begin
                if (dcnt == '0) begin
                    state_nxt   = ST_PULSE;
                    dcnt_nxt    = len_m1;
                    enter_pulse = 1'b1;
                end else begin
                    dcnt_nxt    = dcnt - CNT_W'(1);
                end
            end

            default: begin // ST_PULSE
                if (dcnt == '0) begin
                    state_nxt = sh_auto ? ST_ARMED : ST_IDLE;
                end else begin
                    dcnt_nxt  = dcnt - CNT_W'(1);
                end
            end
        endcase

        // Abort overrides any transition, including a pending pulse entry.
        if (I_disarm) begin
            state_nxt   = ST_IDLE;
            enter_pulse = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State, down-counter and shadow registers
    // ------------------------------------------------------------------------
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            dcnt     <= '0;
            sh_delay <= '0;
            sh_len   <= '0;
            sh_sel   <= '0;
            sh_auto  <= 1'b0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            // Capture configuration only on an accepted arm.
            if ((state == ST_IDLE) && (state_nxt == ST_ARMED)) begin
                sh_delay <= I_delay;
                sh_len   <= I_pulse_len;
                sh_sel   <= I_source_sel;
                sh_auto  <= I_auto_rearm;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Trigger counter: clear beats increment, increment saturates.
    // ------------------------------------------------------------------------
    always_ff @(posedge trace_clk) begin
        if (reset) begin
            trig_count <= '0;
        end else if (I_count_clr) begin
            trig_count <= '0;
        end else if (enter_pulse && (trig_count != '1)) begin
            trig_count <= trig_count + pCOUNT_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs, all decoded from registers
    // ------------------------------------------------------------------------
    assign O_trig_out       = (state == ST_PULSE);
    assign O_armed          = (state == ST_ARMED);
    assign O_busy           = (state == ST_DELAY) || (state == ST_PULSE);
    assign O_capture_active = (state != ST_IDLE);
    assign O_trig_count     = trig_count;

endmodule

// File: tb/tb_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// tb_trigger_sequencer
//
// Directed bench for trigger_sequencer. A second instance with a 2-bit counter
// shares all stimulus and exercises counter saturation. When the design is
// built with TRIG_SEQ_GLITCH_FILTER_EN, FLT shifts the expected latencies by
// one cycle.
// -----------------------------------------------------------------------------
module tb_trigger_sequencer;

`ifdef TRIG_SEQ_GLITCH_FILTER_EN
    localparam int FLT = 1;
`else
    localparam int FLT = 0;
`endif

    logic        trace_clk = 1'b0;
    logic        reset;
    logic        I_m3_trig;
    logic        I_trace_trig;
    logic [1:0]  I_source_sel;
    logic        I_arm;
    logic        I_disarm;
    logic        I_auto_rearm;
    logic [15:0] I_delay;
    logic [15:0] I_pulse_len;
    logic        I_count_clr;
    logic        O_trig_out;
    logic        O_armed;
    logic        O_busy;
    logic        O_capture_active;
    logic [15:0] O_trig_count;

    logic        trig2;
    logic        armed2;
    logic        busy2;
    logic        cap2;
    logic [1:0]  count2;

    int tests  = 0;
    int fails  = 0;
    int npulse = 0;
    logic trig_prev = 1'b0;

    always #5 trace_clk = ~trace_clk;

    trigger_sequencer u_dut (
        .trace_clk        (trace_clk),
        .reset            (reset),
        .I_m3_trig        (I_m3_trig),
        .I_trace_trig     (I_trace_trig),
        .I_source_sel     (I_source_sel),
        .I_arm            (I_arm),
        .I_disarm         (I_disarm),
        .I_auto_rearm     (I_auto_rearm),
        .I_delay          (I_delay),
        .I_pulse_len      (I_pulse_len),
        .I_count_clr      (I_count_clr),
        .O_trig_out       (O_trig_out),
        .O_armed          (O_armed),
        .O_busy           (O_busy),
        .O_capture_active (O_capture_active),
        .O_trig_count     (O_trig_count)
    );

    trigger_sequencer #(.pCOUNT_WIDTH(2)) u_sat (
        .trace_clk        (trace_clk),
        .reset            (reset),
        .I_m3_trig        (I_m3_trig),
        .I_trace_trig     (I_trace_trig),
        .I_source_sel     (I_source_sel),
        .I_arm            (I_arm),
        .I_disarm         (I_disarm),
        .I_auto_rearm     (I_auto_rearm),
        .I_delay          (I_delay),
        .I_pulse_len      (I_pulse_len),
        .I_count_clr      (I_count_clr),
        .O_trig_out       (trig2),
        .O_armed          (armed2),
        .O_busy           (busy2),
        .O_capture_active (cap2),
        .O_trig_count     (count2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are stable 1 time unit after the edge. Also counts
    // rising edges of the trigger output for the multi-pulse checks.
    task automatic tick();
        @(posedge trace_clk);
        #1;
        if (O_trig_out && !trig_prev) npulse++;
        trig_prev = O_trig_out;
    endtask

    task automatic arm();
        I_arm = 1'b1;
        tick();
        I_arm = 1'b0;
    endtask

    initial begin
        int base;
        int any_trig;

        reset        = 1'b1;
        I_m3_trig    = 1'b0;
        I_trace_trig = 1'b0;
        I_source_sel = 2'd0;
        I_arm        = 1'b0;
        I_disarm     = 1'b0;
        I_auto_rearm = 1'b0;
        I_delay      = 16'd0;
        I_pulse_len  = 16'd1;
        I_count_clr  = 1'b0;
        #2;
        tick(); tick();

        // ---- reset state
        chk("rst_trig",   O_trig_out, 0);
        chk("rst_armed",  O_armed, 0);
        chk("rst_busy",   O_busy, 0);
        chk("rst_cap",    O_capture_active, 0);
        chk("rst_count",  O_trig_count, 0);
        reset = 1'b0;
        tick();

        // ---- source 0, delay 0, len 1
        arm();
        chk("t1_armed", O_armed, 1);
        chk("t1_cap",   O_capture_active, 1);
        tick();
        I_m3_trig = 1'b1;
        tick();
        repeat (FLT) tick();
        chk("t1_trig",  O_trig_out, 1);
        chk("t1_count", O_trig_count, 1);
        tick();
        chk("t1_trig_off", O_trig_out, 0);
        chk("t1_idle",     O_capture_active, 0);
        chk("t1_count2",   O_trig_count, 1);
        chk("t1_sat_cnt",  count2, 1);
        I_m3_trig = 1'b0;
        tick();

        // ---- source 1, delay 5, len 3; inputs changed after arm must not matter
        I_source_sel = 2'd1;
        I_delay      = 16'd5;
        I_pulse_len  = 16'd3;
        arm();
        I_delay      = 16'd9;
        I_pulse_len  = 16'd7;
        I_source_sel = 2'd0;
        tick();
        I_trace_trig = 1'b1;
        tick();
        repeat (FLT) tick();
        for (int k = 0; k <= 8; k++) begin
            chk($sformatf("t2_trig_k%0d", k), O_trig_out, (k >= 5 && k <= 7) ? 1 : 0);
            chk($sformatf("t2_busy_k%0d", k), O_busy, (k <= 7) ? 1 : 0);
            tick();
        end
        chk("t2_count", O_trig_count, 2);
        I_trace_trig = 1'b0;
        tick();

        // ---- auto-rearm, 4 edges 10 cycles apart, delay 2, len 2, extra edge in PULSE
        I_source_sel = 2'd0;
        I_delay      = 16'd2;
        I_pulse_len  = 16'd2;
        I_auto_rearm = 1'b1;
        arm();
        I_auto_rearm = 1'b0;
        base = npulse;
        for (int e = 0; e < 4; e++) begin
            I_m3_trig = 1'b1;
            tick(); tick();
            I_m3_trig = 1'b0;
            tick();
            if (e == 1) I_m3_trig = 1'b1;
            tick(); tick();
            I_m3_trig = 1'b0;
            repeat (5) tick();
        end
        chk("t3_pulses", npulse - base, 4);
        chk("t3_count",  O_trig_count, 6);
        chk("t3_armed",  O_armed, 1);
        chk("t3_sat",    count2, 3);
        I_disarm = 1'b1;
        tick();
        I_disarm = 1'b0;
        chk("t3_disarm", O_armed, 0);

        // ---- level already high at arm
        I_delay     = 16'd0;
        I_pulse_len = 16'd1;
        I_m3_trig   = 1'b1;
        tick(); tick();
        arm();
        any_trig = 0;
        repeat (6) begin
            tick();
            if (O_trig_out) any_trig = 1;
        end
        chk("t4_high_notrig", any_trig, 0);
        chk("t4_high_armed",  O_armed, 1);
        I_m3_trig = 1'b0;
        I_disarm  = 1'b1;
        tick();
        I_disarm  = 1'b0;

        // ---- source 3 (AND), only M3 toggles
        I_source_sel = 2'd3;
        arm();
        any_trig = 0;
        for (int i = 0; i < 8; i++) begin
            I_m3_trig = (i % 3 != 2);
            tick();
            if (O_trig_out) any_trig = 1;
        end
        I_m3_trig = 1'b0;
        chk("t4_and_notrig", any_trig, 0);
        chk("t4_and_armed",  O_armed, 1);
        chk("t4_count",      O_trig_count, 6);
        I_disarm = 1'b1;
        tick();
        I_disarm = 1'b0;

        // ---- disarm during DELAY
        I_source_sel = 2'd0;
        I_delay      = 16'd5;
        arm();
        I_m3_trig = 1'b1;
        tick();
        repeat (FLT) tick();
        chk("t5_in_delay", O_busy, 1);
        tick();
        I_disarm = 1'b1;
        tick();
        I_disarm = 1'b0;
        chk("t5_armed", O_armed, 0);
        chk("t5_busy",  O_busy, 0);
        chk("t5_cap",   O_capture_active, 0);
        any_trig = 0;
        repeat (8) begin
            tick();
            if (O_trig_out) any_trig = 1;
        end
        chk("t5_notrig", any_trig, 0);
        I_m3_trig = 1'b0;
        tick();

        // ---- arm + disarm together in IDLE
        I_arm    = 1'b1;
        I_disarm = 1'b1;
        tick();
        I_arm    = 1'b0;
        I_disarm = 1'b0;
        chk("t5_ad_armed", O_armed, 0);
        chk("t5_ad_cap",   O_capture_active, 0);
        chk("t5_count",    O_trig_count, 6);

        // ---- clear coincident with PULSE entry
        I_delay = 16'd0;
        arm();
        I_m3_trig = 1'b1;
        repeat (FLT) tick();
        I_count_clr = 1'b1;
        tick();
        I_count_clr = 1'b0;
        chk("t6_trig",  O_trig_out, 1);
        chk("t6_count", O_trig_count, 0);
        chk("t6_sat",   count2, 0);
        tick();
        I_m3_trig = 1'b0;
        tick();

        // ---- zero pulse length acts as one cycle
        I_pulse_len = 16'd0;
        arm();
        I_m3_trig = 1'b1;
        tick();
        repeat (FLT) tick();
        chk("t7_len0_on",  O_trig_out, 1);
        tick();
        chk("t7_len0_off", O_trig_out, 0);
        chk("t7_count",    O_trig_count, 1);
        I_m3_trig = 1'b0;
        tick();

        // ---- single-cycle glitch: triggers only without the filter
        base = npulse;
        arm();
        I_m3_trig = 1'b1;
        tick();
        I_m3_trig = 1'b0;
        repeat (4) tick();
        chk("t8_glitch", npulse - base, (FLT == 0) ? 1 : 0);
        I_disarm = 1'b1;
        tick();
        I_disarm = 1'b0;

        // ---- reset mid-pulse
        I_pulse_len = 16'd4;
        arm();
        I_m3_trig = 1'b1;
        tick();
        repeat (FLT) tick();
        chk("t9_pulse", O_trig_out, 1);
        reset = 1'b1;
        tick();
        chk("t9_rst_trig",  O_trig_out, 0);
        chk("t9_rst_count", O_trig_count, 0);
        chk("t9_rst_cap",   O_capture_active, 0);
        reset     = 1'b0;
        I_m3_trig = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
